// File: rtl/intsequencer_if.sv
// ---------------------------------------------------------------------------
// intsequencer_if
//
// Purpose: groups the signals exchanged between the interrupt/reset
// sequencer and the 6502 instruction/cycle controller + decoder.
//
// Signals:
//   sync     - opcode-fetch cycle indicator (controller -> sequencer)
//   brk      - current instruction is a software BRK (decoder -> sequencer)
//   vec_done - vector high byte loaded into PC, 1-cycle pulse (decoder -> sequencer)
//   irq      - force fetched opcode to 8'h00 (sequencer -> controller)
//   vector   - vector low-byte address (sequencer -> datapath)
//   bflag    - B value to push (sequencer -> datapath)
//   nowrite  - suppress stack writes (sequencer -> datapath)
//
// Modports:
//   master - controller/decoder/datapath side
//   slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface intsequencer_if;
    logic        sync;
    logic        brk;
    logic        vec_done;
    logic        irq;
    logic [15:0] vector;
    logic        bflag;
    logic        nowrite;

    modport master (
        output sync,
        output brk,
        output vec_done,
        input  irq,
        input  vector,
        input  bflag,
        input  nowrite
    );

    modport slave (
        input  sync,
        input  brk,
        input  vec_done,
        output irq,
        output vector,
        output bflag,
        output nowrite
    );
endinterface

// File: rtl/intsequencer.sv
// ---------------------------------------------------------------------------
// intsequencer
//
// Purpose: interrupt and reset sequencer for the 6502 core. Detects NMI
// falling edges and IRQ levels, arbitrates reset > NMI > IRQ, asks the
// cycle controller to inject opcode 8'h00 at the next opcode fetch, and
// provides the vector address / B flag / stack-write suppression for the
// duration of the service sequence.
//
// Ports:
//   clk    - core clock, rising edge
//   rst    - asynchronous reset, active low
//   nmi_n  - NMI pin, active low, falling-edge triggered
//   irq_n  - IRQ pin, active low, level sensitive
//   iflag  - status register I bit, 1 masks IRQ
//   bus    - intsequencer_if.slave (sync, brk, vec_done in;
//            irq, vector, bflag, nowrite out)
//
// Configuration macro:
//   INTSEQ_PIN_SYNC_EN - when defined, nmi_n and irq_n pass through a
//                        2-flop synchronizer (reset to 1) before edge/level
//                        detection, adding 2 cycles of detection latency.
//                        When undefined the pins are used directly.
// ---------------------------------------------------------------------------
module intsequencer (
    input  logic          clk,
    input  logic          rst,
    input  logic          nmi_n,
    input  logic          irq_n,
    input  logic          iflag,
    intsequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES = 2'd0,
        NMI = 2'd1,
        IRQ = 2'd2
    } src_t;

    localparam logic [15:0] VEC_RES = 16'hFFFC;
    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    state_t state;
    state_t state_nxt;
    src_t   src;
    src_t   src_nxt;
    logic   nmi_pend;
    logic   nmi_pend_nxt;
    logic   nmi_q;

    // Pin values as seen by the detection logic (raw or synchronized).
    logic   nmi_pin;
    logic   irq_pin;

    logic   nmi_edge;
    logic   req_nmi;
    logic   req_irq;
    logic   take_nmi;

`ifdef INTSEQ_PIN_SYNC_EN
    logic [1:0] nmi_sync;
    logic [1:0] irq_sync;

    // Two-flop synchronizers. Reset to the inactive pin level so that a
    // reset never fabricates an NMI edge or an IRQ request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nmi_sync <= 2'b11;
            irq_sync <= 2'b11;
        end else begin
            nmi_sync <= {nmi_sync[0], nmi_n};
            irq_sync <= {irq_sync[0], irq_n};
        end
    end

    assign nmi_pin = nmi_sync[1];
    assign irq_pin = irq_sync[1];
`else
    assign nmi_pin = nmi_n;
    assign irq_pin = irq_n;
`endif

    // nmi_q holds the previous pin value, so an edge is "was high, now low".
    // A pin held low produces only one edge; it must return high first.
    assign nmi_edge = nmi_q & ~nmi_pin;
    assign req_nmi  = nmi_pend;
    assign req_irq  = ~irq_pin & ~iflag;

    // The NMI is consumed when its service sequence starts.
    assign take_nmi = (state == PEND) && bus.sync && (src == NMI);

    // State register, source register and NMI latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= PEND;
            src      <= RES;
            nmi_pend <= 1'b0;
            nmi_q    <= 1'b1;
        end else begin
            state    <= state_nxt;
            src      <= src_nxt;
            nmi_pend <= nmi_pend_nxt;
            nmi_q    <= nmi_pin;
        end
    end

    // Next-state logic.
    // In PEND the sync edge has priority: once irq was high during a fetch
    // the controller has already committed to the injected 8'h00, so the
    // sequence must be serviced with the source frozen at that edge.
    // Only an IRQ source can be upgraded or withdrawn; a reset sequence is
    // never displaced, and a pending NMI waits until it finishes.
    always_comb begin
        state_nxt = state;
        src_nxt   = src;
        case (state)
            IDLE: begin
                if (req_nmi || req_irq) begin
                    state_nxt = PEND;
                    src_nxt   = req_nmi ? NMI : IRQ;
                end
            end
            PEND: begin
                if (bus.sync) begin
                    state_nxt = SERVICE;
                end else if (src == IRQ) begin
                    if (nmi_pend) begin
                        src_nxt = NMI;
                    end else if (!req_irq) begin
                        state_nxt = IDLE;
                    end
                end
            end
            SERVICE: begin
                if (bus.vec_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A fresh edge on the same clock as the consume wins, so a second
        // NMI arriving right at service entry is not lost.
        nmi_pend_nxt = nmi_pend;
        if (take_nmi) begin
            nmi_pend_nxt = 1'b0;
        end
        if (nmi_edge) begin
            nmi_pend_nxt = 1'b1;
        end
    end

    // Output logic. Outside a sequence the vector defaults to the IRQ/BRK
    // vector so a software BRK fetches the right address.
    always_comb begin
        bus.irq     = (state == PEND);
        bus.bflag   = bus.brk && (state == IDLE);
        bus.nowrite = (src == RES) && (state != IDLE);
        bus.vector  = VEC_IRQ;
        if (state != IDLE) begin
            case (src)
                RES:     bus.vector = VEC_RES;
                NMI:     bus.vector = VEC_NMI;
                default: bus.vector = VEC_IRQ;
            endcase
        end
    end

endmodule

// File: tb/tb_intsequencer.sv
// ---------------------------------------------------------------------------
// tb_intsequencer
//
// Purpose: self-checking bench for intsequencer. A behavioural model of the
// sequencer (pending flag, servicing flag, vector of the current source,
// owed-NMI latch, pin history) predicts every output on every cycle; a few
// directed scenarios also check hand-computed literal values. Directed
// scenarios are followed by a long randomized run with occasional resets.
// Honours INTSEQ_PIN_SYNC_EN by delaying the model's view of the pins.
// ---------------------------------------------------------------------------
module tb_intsequencer;

    localparam logic [15:0] VEC_RES = 16'hFFFC;
    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

`ifdef INTSEQ_PIN_SYNC_EN
    localparam int PIN_DELAY = 2;
`else
    localparam int PIN_DELAY = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic nmi_n;
    logic irq_n;
    logic iflag;

    intsequencer_if bus();

    intsequencer dut (
        .clk   (clk),
        .rst   (rst),
        .nmi_n (nmi_n),
        .irq_n (irq_n),
        .iflag (iflag),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // -------------------------------------------------------------------
    // Behavioural model.
    //   m_inject   : an 8'h00 injection is requested (waiting for fetch)
    //   m_serve    : a service sequence is running
    //   m_src_vec  : vector of the source being handled
    //   m_nmi_owed : an NMI edge has been seen and not yet serviced
    //   *_hist     : pin values at past edges, [0] = most recent edge
    // -------------------------------------------------------------------
    logic        m_inject;
    logic        m_serve;
    logic [15:0] m_src_vec;
    logic        m_nmi_owed;
    logic [2:0]  nmi_hist;
    logic [2:0]  irq_hist;

    logic        nmi_seen;
    logic        irq_seen;
    logic        nmi_before;
    logic        nmi_fell;
    logic        irq_wanted;
    logic        n_inject;
    logic        n_serve;
    logic [15:0] n_src_vec;
    logic        n_nmi_owed;

    // The pins as the sequencer's detector sees them, shifted by the
    // optional synchronizer depth.
    always_comb begin
`ifdef INTSEQ_PIN_SYNC_EN
        nmi_seen   = nmi_hist[1];
        irq_seen   = irq_hist[1];
        nmi_before = nmi_hist[2];
`else
        nmi_seen   = nmi_n;
        irq_seen   = irq_n;
        nmi_before = nmi_hist[0];
`endif
    end

    // What should happen at the coming clock edge.
    always_comb begin
        nmi_fell   = nmi_before & ~nmi_seen;
        irq_wanted = ~irq_seen & ~iflag;
        n_inject   = m_inject;
        n_serve    = m_serve;
        n_src_vec  = m_src_vec;
        n_nmi_owed = m_nmi_owed;
        if (m_inject) begin
            if (bus.sync) begin
                n_inject = 1'b0;
                n_serve  = 1'b1;
                if (m_src_vec == VEC_NMI) n_nmi_owed = 1'b0;
            end else if (m_src_vec == VEC_IRQ) begin
                if (m_nmi_owed)       n_src_vec = VEC_NMI;
                else if (!irq_wanted) n_inject  = 1'b0;
            end
        end else if (m_serve) begin
            if (bus.vec_done) n_serve = 1'b0;
        end else if (m_nmi_owed || irq_wanted) begin
            n_inject  = 1'b1;
            n_src_vec = m_nmi_owed ? VEC_NMI : VEC_IRQ;
        end
        if (nmi_fell) n_nmi_owed = 1'b1;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_inject   <= 1'b1;
            m_serve    <= 1'b0;
            m_src_vec  <= VEC_RES;
            m_nmi_owed <= 1'b0;
            nmi_hist   <= 3'b111;
            irq_hist   <= 3'b111;
        end else begin
            m_inject   <= n_inject;
            m_serve    <= n_serve;
            m_src_vec  <= n_src_vec;
            m_nmi_owed <= n_nmi_owed;
            nmi_hist   <= {nmi_hist[1:0], nmi_n};
            irq_hist   <= {irq_hist[1:0], irq_n};
        end
    end

    // -------------------------------------------------------------------
    // Checking helpers
    // -------------------------------------------------------------------
    task automatic checkValue(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h",
                     name, $time, actual, expected);
        end
    endtask

    // Compare every output against the model.
    task automatic checkOutput();
        logic busy;
        busy = m_inject | m_serve;
        checkValue("irq",     {15'd0, bus.irq},     {15'd0, m_inject});
        checkValue("vector",  bus.vector,           busy ? m_src_vec : VEC_IRQ);
        checkValue("bflag",   {15'd0, bus.bflag},   {15'd0, bus.brk & ~busy});
        checkValue("nowrite", {15'd0, bus.nowrite}, {15'd0, busy & (m_src_vec == VEC_RES)});
    endtask

    // Advance to the next falling edge and check the model there.
    task automatic stepTo();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input logic r, input logic nm, input logic iq,
                                 input logic ifl, input logic sy, input logic bk,
                                 input logic vd);
        rst          = r;
        nmi_n        = nm;
        irq_n        = iq;
        iflag        = ifl;
        bus.sync     = sy;
        bus.brk      = bk;
        bus.vec_done = vd;
    endtask

    task automatic expectLit(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
        checkValue(name, actual, expected);
    endtask

    logic r_rst, r_nmi, r_irq, r_if;

    initial begin
        $display("[TB] start, pin delay %0d", PIN_DELAY);

        // Reset state.
        applyStimulus(0, 1, 1, 1, 0, 0, 0);
        stepTo();
        expectLit("rst_irq",     {15'd0, bus.irq},     16'd1);
        expectLit("rst_vector",  bus.vector,           16'hFFFC);
        expectLit("rst_nowrite", {15'd0, bus.nowrite}, 16'd1);
        expectLit("rst_bflag",   {15'd0, bus.bflag},   16'd0);

        // Reset sequence: stays pending without sync.
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            stepTo();
            expectLit("res_pend_irq", {15'd0, bus.irq}, 16'd1);
            expectLit("res_pend_vec", bus.vector,       16'hFFFC);
        end
        applyStimulus(1, 1, 1, 1, 1, 0, 0);
        stepTo();
        expectLit("res_svc_irq",     {15'd0, bus.irq},     16'd0);
        expectLit("res_svc_nowrite", {15'd0, bus.nowrite}, 16'd1);
        expectLit("res_svc_vec",     bus.vector,           16'hFFFC);
        applyStimulus(1, 1, 1, 1, 0, 0, 1);
        stepTo();
        expectLit("res_done_irq",     {15'd0, bus.irq},     16'd0);
        expectLit("res_done_nowrite", {15'd0, bus.nowrite}, 16'd0);
        expectLit("res_done_vec",     bus.vector,           16'hFFFE);
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
        stepTo();

        // IRQ unmasked.
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < PIN_DELAY; i++) stepTo();
        stepTo();
        expectLit("irq_pend_irq", {15'd0, bus.irq}, 16'd1);
        expectLit("irq_pend_vec", bus.vector,       16'hFFFE);
        stepTo();
        stepTo();
        expectLit("irq_hold_irq", {15'd0, bus.irq}, 16'd1);
        applyStimulus(1, 1, 0, 0, 1, 0, 0);
        stepTo();
        expectLit("irq_svc_irq",     {15'd0, bus.irq},     16'd0);
        expectLit("irq_svc_vec",     bus.vector,           16'hFFFE);
        expectLit("irq_svc_nowrite", {15'd0, bus.nowrite}, 16'd0);
        expectLit("irq_svc_bflag",   {15'd0, bus.bflag},   16'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        stepTo();
        applyStimulus(1, 1, 1, 1, 0, 0, 1);
        stepTo();
        expectLit("irq_done_irq", {15'd0, bus.irq}, 16'd0);
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < PIN_DELAY + 2; i++) stepTo();

        // NMI while IRQ is masked; held-low NMI gives only one service.
        applyStimulus(1, 1, 0, 1, 0, 0, 0);
        stepTo();
        stepTo();
        expectLit("masked_irq", {15'd0, bus.irq}, 16'd0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 1 + PIN_DELAY; i++) stepTo();
        stepTo();
        expectLit("nmi_pend_irq", {15'd0, bus.irq}, 16'd1);
        expectLit("nmi_pend_vec", bus.vector,       16'hFFFA);
        applyStimulus(1, 0, 0, 1, 1, 0, 0);
        stepTo();
        expectLit("nmi_svc_irq", {15'd0, bus.irq}, 16'd0);
        expectLit("nmi_svc_vec", bus.vector,       16'hFFFA);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        stepTo();
        expectLit("nmi_done_vec", bus.vector, 16'hFFFE);
        applyStimulus(1, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) stepTo();
        expectLit("nmi_once_irq", {15'd0, bus.irq}, 16'd0);
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < PIN_DELAY + 2; i++) stepTo();

        // IRQ pending upgraded by NMI, then IRQ serviced afterwards.
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < PIN_DELAY; i++) stepTo();
        stepTo();
        expectLit("upg_irq_vec", bus.vector, 16'hFFFE);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1 + PIN_DELAY; i++) stepTo();
        stepTo();
        expectLit("upg_nmi_vec", bus.vector,       16'hFFFA);
        expectLit("upg_nmi_irq", {15'd0, bus.irq}, 16'd1);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        stepTo();
        expectLit("upg_svc_vec", bus.vector, 16'hFFFA);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        stepTo();
        expectLit("upg_done_irq", {15'd0, bus.irq}, 16'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        stepTo();
        expectLit("upg_next_irq", {15'd0, bus.irq}, 16'd1);
        expectLit("upg_next_vec", bus.vector,       16'hFFFE);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        stepTo();
        applyStimulus(1, 1, 1, 1, 0, 0, 1);
        stepTo();
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < PIN_DELAY + 2; i++) stepTo();

        // IRQ withdrawn before the fetch.
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < PIN_DELAY; i++) stepTo();
        stepTo();
        expectLit("wd_pend_irq", {15'd0, bus.irq}, 16'd1);
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < PIN_DELAY; i++) stepTo();
        stepTo();
        expectLit("wd_idle_irq", {15'd0, bus.irq}, 16'd0);
        applyStimulus(1, 1, 1, 0, 1, 0, 0);
        stepTo();
        expectLit("wd_fetch_irq", {15'd0, bus.irq}, 16'd0);
        expectLit("wd_fetch_vec", bus.vector,       16'hFFFE);

        // Software BRK in IDLE.
        applyStimulus(1, 1, 1, 1, 0, 1, 0);
        stepTo();
        expectLit("brk_bflag", {15'd0, bus.bflag}, 16'd1);
        expectLit("brk_vec",   bus.vector,         16'hFFFE);
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
        stepTo();

        // Randomized run with occasional reset pulses.
        r_nmi = 1'b1;
        r_irq = 1'b1;
        r_if  = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            r_rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 7) == 0) r_nmi = ~r_nmi;
            if ($urandom_range(0, 9) == 0) r_irq = ~r_irq;
            if ($urandom_range(0, 11) == 0) r_if = ~r_if;
            applyStimulus(r_rst, r_nmi, r_irq, r_if,
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 2) == 0));
            stepTo();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/intsequencer.md
# intsequencer

Interrupt and reset sequencer for the 6502 core, directly upstream of the instruction/cycle controller. Detects NMI edges and IRQ levels, arbitrates reset > NMI > IRQ, drives the controller's `irq` input so it injects opcode 8'h00 at the next opcode fetch, and supplies the vector address and B-flag value to the datapath for the duration of the service sequence.

## Interface
- No parameters.
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `nmi_n` input 1: NMI pin, active low, edge-triggered (falling edge).
- `irq_n` input 1: IRQ pin, active low, level-sensitive.
- `iflag` input 1: I bit from the status register; 1 masks IRQ.
- `sync` input 1: opcode-fetch cycle indicator from the instruction/cycle controller.
- `brk` input 1: decoder flag; the current instruction is a software BRK, not an injected one.
- `vec_done` input 1: one-cycle pulse from the decoder when the vector high byte has been loaded into the PC.
- `irq` output 1: to the instruction/cycle controller; 1 forces the fetched opcode to 8'h00.
- `vector` output 16: vector low-byte address: 16'hFFFC reset, 16'hFFFA NMI, 16'hFFFE IRQ/BRK.
- `bflag` output 1: B value to push; 1 only for software BRK.
- `nowrite` output 1: 1 suppresses stack writes (reset sequence only).

## Operation
- States: IDLE, PEND, SERVICE. Source register `src` is one of RES, NMI, IRQ.
- Pin sampling: `nmi_q` registers `nmi_n` every edge. An NMI edge is `nmi_q & ~nmi_n`, which sets `nmi_pend` at that same edge.
- `req_nmi = nmi_pend`. `req_irq = ~irq_n & ~iflag`.
- IDLE → PEND on any edge with `req_nmi | req_irq`. `src` is NMI if `req_nmi`, else IRQ.
- In PEND, `src` is upgraded to NMI if `nmi_pend` rises. If `src` is IRQ and `req_irq` drops with no NMI pending, the state returns to IDLE (IRQ withdrawn).
- PEND → SERVICE on an edge with `sync=1`. `src` is frozen at this edge. If `src` is NMI, `nmi_pend` is cleared at the same edge; a new NMI edge at that same edge wins and keeps `nmi_pend=1`.
- SERVICE → IDLE on `vec_done`. Requests arriving during SERVICE stay pending and are evaluated from IDLE.
- `irq` = (state==PEND).
- `vector`:
  - In PEND or SERVICE, `vector` is selected by `src`.
  - In IDLE, `vector` is 16'hFFFE.
- `bflag` = `brk` & (state==IDLE). An injected 8'h00 never reports B=1.
- `nowrite` = (`src`==RES) & (state != IDLE).

## Timing
- Reset values (rst low):
  - state=PEND, `src`=RES, `nmi_pend`=0, `nmi_q`=1.
  - Outputs: `irq`=1, `vector`=16'hFFFC, `nowrite`=1, `bflag`=0.
- After reset release, the first `sync` edge enters SERVICE. The reset sequence ends on `vec_done`.
- Reset asserted mid-service aborts immediately and restarts the reset sequence; any pending NMI is lost.
- NMI latency, no synchronizer: `nmi_n` low before edge k gives `nmi_pend=1` and (from IDLE) PEND after edge k+1.
- `irq` rises one edge after the request is seen and stays high until the `sync` edge.
- `nmi_n` held low indefinitely produces exactly one NMI; a new NMI requires a rising then a falling edge.
- Simultaneous `vec_done` and a new request: the state goes to IDLE this edge and to PEND next edge.
- `vec_done` outside SERVICE is ignored.

## Configuration
- `INTSEQ_PIN_SYNC_EN` defined:
  - `nmi_n` and `irq_n` pass through a 2-flop synchronizer before edge/level detection.
  - `nmi_q` samples the synchronized NMI.
  - NMI and IRQ detection latency grows by 2 cycles.
  - Synchronizer flops reset to 1.
- Not defined: the pins are used directly, with the timing stated above.

## Test plan
- Reset release, hold `sync=0` for 3 cycles, then pulse `sync`, then pulse `vec_done` → `irq`=1 and `vector`=16'hFFFC with `nowrite`=1 until `vec_done`, then IDLE with `irq`=0 and `nowrite`=0.
- `iflag`=0, `irq_n` low at cycle 10, `sync` at cycle 14 → `irq`=1 in cycles 11–14, `vector`=16'hFFFE, SERVICE until `vec_done`, `bflag`=0 throughout.
- `iflag`=1 with `irq_n` low, then `nmi_n` falls → IRQ ignored, NMI serviced with `vector`=16'hFFFA, and `nmi_n` held low afterwards causes no second NMI.
- In PEND with `src`=IRQ, `nmi_n` falls before `sync` → `src` upgrades to NMI and `vector`=16'hFFFA at the `sync` edge; IRQ is serviced after `vec_done` if still asserted.
- In PEND(IRQ), `irq_n` deasserts before `sync` → back to IDLE and `irq`=0; the next fetch is not forced to 8'h00.
- In IDLE with `brk`=1 → `bflag`=1 and `vector`=16'hFFFE. With `INTSEQ_PIN_SYNC_EN`, repeat the NMI test and expect PEND 2 cycles later.
